register_scoreboard: RTL
========================

REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 MAX_INFLIGHT, 3, maximum outstanding register-writing instructions between decode and writeback (1..7).
REQ-002 COUNT_WIDTH, 3, width of per-register and global pending counters; SHALL be >= clog2(MAX_INFLIGHT+1).
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 issueValid  in  1  decode presents an instruction this cycle.
REQ-006 issueReady  out  1  instruction may issue; issue fires when issueValid && issueReady.
REQ-007 issueReadId1, issueReadId2  in  5 each  source register ids.
REQ-008 issueReadUsed  in  2  bit0/bit1: source 1/2 is actually read.
REQ-009 issueWriteEnabled  in  1  instruction writes a register.
REQ-010 issueWriteId  in  5  destination register id.
REQ-011 retireValid  in  1  writeback commits a register write this cycle.
REQ-012 retireWriteId  in  5  register committed.
REQ-013 stallReason  out  2  0 none, 1 RAW hazard, 2 in-flight limit full.
REQ-014 pendingMask  out  32  bit n set when register n has count > 0.
REQ-015 inFlight  out  COUNT_WIDTH  global outstanding-writer count.
REQ-016 underflowError  out  1  sticky: retire seen for register with zero count.

Function
REQ-017 Per-register counter cnt[1..31] of COUNT_WIDTH bits; register 0 never tracked, cnt[0] reads 0.
REQ-018 RAW hazard: for each used port with id != 0, cnt[id] > 0 and not (retireValid && retireWriteId == id && cnt[id] == 1).
REQ-019 Full: issueWriteEnabled && issueWriteId != 0 && inFlight == MAX_INFLIGHT && !(retireValid && retireWriteId != 0 && cnt[retireWriteId] != 0).
REQ-020 issueReady = !hazard && !full, combinational; issueReady SHALL NOT depend on issueValid.
REQ-021 stallReason = 1 if hazard, else 2 if full, else 0; evaluated regardless of issueValid.
REQ-022 Issue fire with issueWriteEnabled and issueWriteId != 0: cnt[issueWriteId] and inFlight +1 next edge.
REQ-023 Retire with retireWriteId != 0 and cnt > 0: cnt[retireWriteId] and inFlight -1 next edge.
REQ-024 Issue and retire same register same cycle: cnt unchanged, inFlight unchanged.
REQ-025 Issue and retire different registers same cycle: both applied; inFlight unchanged.
REQ-026 Retire of register 0: no state change, no error.
REQ-027 Retire with cnt == 0 (id != 0): counters unchanged, underflowError set to 1, held until reset.
REQ-028 Counters SHALL never wrap; increment at all-ones is blocked (saturate).
REQ-029 Instructions with issueWriteEnabled == 0 or issueWriteId == 0 fire without changing state.
REQ-030 Latency: retire visible to hazard check same cycle (REQ-018 bypass); issue visible from next cycle.

Reset
REQ-031 On reset assertion, immediately: all cnt = 0, inFlight = 0, underflowError = 0; hence pendingMask = 0, issueReady = 1 when no hazard inputs, stallReason = 0.
REQ-032 Reset mid-operation discards all pending state; retires arriving after reset release for pre-reset issues raise underflowError.

Configuration
REQ-033 Macro SCOREBOARD_STATS_EN defined: adds output stallCycles (32 bits), incremented each cycle issueValid && !issueReady, wraps at 2^32, cleared by reset.
REQ-034 Macro undefined: stallCycles port and counter absent; all other behaviour identical.

Verification
REQ-035 Issue write $5; next cycle issue read $5 -> issueReady 0, stallReason 1, pendingMask bit5 1.
REQ-036 cnt[$5]=1; same cycle retire $5 and issue read $5 -> issueReady 1; next cycle cnt[$5]=0, pendingMask 0.
REQ-037 Issue writes $1,$2,$3 (MAX_INFLIGHT 3); issue write $4 -> stallReason 2; add retire $1 same cycle -> issueReady 1, inFlight stays 3.
REQ-038 Issue write $0, read $0 with nothing pending -> issueReady 1, inFlight 0, pendingMask 0.
REQ-039 Retire $7 with cnt 0 -> underflowError 1 held; assert reset mid-cycle -> all outputs return to reset values before next edge.
REQ-040 With SCOREBOARD_STATS_EN: 4 stalled valid cycles then 2 ready cycles -> stallCycles 4.

Source files
------------

// File: rtl/register_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : register_scoreboard
//  Purpose  : Register-write scoreboard between decode and writeback. Tracks
//             outstanding writers per architectural register (1..31) and a
//             global in-flight count, and blocks issue on RAW hazards or when
//             the in-flight limit is reached. A retire in the current cycle is
//             bypassed into both hazard and limit checks.
//  Option   : SCOREBOARD_STATS_EN - adds a 32-bit stallCycles counter output.
//  Revision : 1.0 - initial release
// ============================================================================
module register_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int COUNT_WIDTH  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   issueValid,
    output logic                   issueReady,
    input  logic [4:0]             issueReadId1,
    input  logic [4:0]             issueReadId2,
    input  logic [1:0]             issueReadUsed,
    input  logic                   issueWriteEnabled,
    input  logic [4:0]             issueWriteId,
    input  logic                   retireValid,
    input  logic [4:0]             retireWriteId,
    output logic [1:0]             stallReason,
    output logic [31:0]            pendingMask,
    output logic [COUNT_WIDTH-1:0] inFlight,
    output logic                   underflowError
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]            stallCycles
`endif
);

    localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] C_LIMIT   = COUNT_WIDTH'(MAX_INFLIGHT);
    localparam logic [COUNT_WIDTH-1:0] C_ONE     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] C_ZERO    = '0;

    // Per-register counts as seen by all lookups; entry 0 is hard-wired zero.
    logic [COUNT_WIDTH-1:0] w_cnt [32];

    logic [COUNT_WIDTH-1:0] r_inFlight;
    logic                   r_underflow;

    logic [COUNT_WIDTH-1:0] w_rdCnt1;
    logic [COUNT_WIDTH-1:0] w_rdCnt2;
    logic [COUNT_WIDTH-1:0] w_retCnt;
    logic [COUNT_WIDTH-1:0] w_wrCnt;
    logic                   w_retireLive;
    logic                   w_retireUnder;
    logic                   w_haz1;
    logic                   w_haz2;
    logic                   w_hazard;
    logic                   w_full;
    logic                   w_fire;
    logic                   w_issueTracked;
    logic                   w_sameReg;
    logic                   w_incOk;

    assign w_rdCnt1 = w_cnt[issueReadId1];
    assign w_rdCnt2 = w_cnt[issueReadId2];
    assign w_retCnt = w_cnt[retireWriteId];
    assign w_wrCnt  = w_cnt[issueWriteId];

    // A retire only counts when it matches a tracked writer; otherwise it is an underflow.
    assign w_retireLive  = retireValid && (retireWriteId != 5'd0) && (w_retCnt != C_ZERO);
    assign w_retireUnder = retireValid && (retireWriteId != 5'd0) && (w_retCnt == C_ZERO);

    // A source is hazardous unless its last outstanding writer retires this very cycle.
    assign w_haz1 = issueReadUsed[0] && (issueReadId1 != 5'd0) && (w_rdCnt1 != C_ZERO) &&
                    !(retireValid && (retireWriteId == issueReadId1) && (w_rdCnt1 == C_ONE));
    assign w_haz2 = issueReadUsed[1] && (issueReadId2 != 5'd0) && (w_rdCnt2 != C_ZERO) &&
                    !(retireValid && (retireWriteId == issueReadId2) && (w_rdCnt2 == C_ONE));
    assign w_hazard = w_haz1 || w_haz2;

    // The limit only blocks instructions that would actually add a tracked writer.
    assign w_full = issueWriteEnabled && (issueWriteId != 5'd0) &&
                    (r_inFlight == C_LIMIT) && !w_retireLive;

    assign issueReady  = !w_hazard && !w_full;
    assign stallReason = w_hazard ? 2'd1 : (w_full ? 2'd2 : 2'd0);

    assign w_fire         = issueValid && issueReady;
    assign w_issueTracked = w_fire && issueWriteEnabled && (issueWriteId != 5'd0);
    assign w_sameReg      = w_retireLive && (retireWriteId == issueWriteId);

    // Saturation guard: a net-zero update (same-register retire) is always safe,
    // otherwise neither the target count nor the global count may be all-ones.
    assign w_incOk = w_issueTracked &&
                     (w_sameReg ||
                      ((w_wrCnt != C_CNT_MAX) && ((r_inFlight != C_CNT_MAX) || w_retireLive)));

    generate
        for (genvar i = 0; i < 32; i++) begin : g_cnt
            if (i == 0) begin : g_zero
                assign w_cnt[i] = C_ZERO;
            end else begin : g_track
                logic [COUNT_WIDTH-1:0] r_cnt;
                logic                   w_inc;
                logic                   w_dec;

                assign w_inc = w_incOk && (issueWriteId == 5'(i));
                assign w_dec = w_retireLive && (retireWriteId == 5'(i));

                // Per-register writer count; simultaneous issue and retire cancel out.
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        r_cnt <= C_ZERO;
                    end else if (w_inc && !w_dec) begin
                        r_cnt <= r_cnt + C_ONE;
                    end else if (w_dec && !w_inc) begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end

                assign w_cnt[i] = r_cnt;
            end
        end
    endgenerate

    // Global outstanding-writer count tracks the sum of the per-register counts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inFlight <= C_ZERO;
        end else if (w_incOk && !w_retireLive) begin
            r_inFlight <= r_inFlight + C_ONE;
        end else if (w_retireLive && !w_incOk) begin
            r_inFlight <= r_inFlight - C_ONE;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_underflow <= 1'b0;
        end else if (w_retireUnder) begin
            r_underflow <= 1'b1;
        end
    end

    // Pending mask derived directly from the counts; bit 0 is never set.
    always_comb begin
        pendingMask = '0;
        for (int i = 1; i < 32; i++) begin
            pendingMask[i] = (w_cnt[i] != C_ZERO);
        end
    end

    assign inFlight       = r_inFlight;
    assign underflowError = r_underflow;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stallCycles;

    // Counts cycles where decode offers an instruction that cannot issue; wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stallCycles <= 32'd0;
        end else if (issueValid && !issueReady) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign stallCycles = r_stallCycles;
`endif

endmodule
`default_nettype wire
